// File: rtl/row_packer.sv
// Packs a stream of 32-bit words into NI-lane rows and hands each row downstream with
// valid/ready, tagging the last row of every ROWS_PER_SUM-row accumulation group.
module row_packer #(
    parameter int unsigned NI           = 8,
    parameter int unsigned ROWS_PER_SUM = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic              flush,
    output logic [NI*32-1:0]  row_out,
    output logic              row_valid,
    input  logic              row_ready,
    output logic              row_last,
    output logic [CNT_W-1:0]  row_index
);

    localparam int unsigned FILL_W = $clog2(NI + 1);

    // Fill stage
    logic [NI-1:0][31:0] fill_q, fill_d;
    logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic                fill_full_q, fill_full_d;
    logic                fill_flushed_q, fill_flushed_d;

    // Output stage
    logic [NI*32-1:0]    row_q, row_d;
    logic                row_valid_q, row_valid_d;
    logic                row_last_q, row_last_d;
    logic [CNT_W-1:0]    row_index_q, row_index_d;

    // Position of the row currently being filled within its group
    logic [CNT_W-1:0]    grp_cnt_q, grp_cnt_d;

    logic word_acc;
    logic flush_acc;
    logic transfer;
    logic grp_last;

    assign word_ready = !fill_full_q;
    assign word_acc   = word_valid && word_ready;
    assign flush_acc  = flush && word_ready;
    assign transfer   = fill_full_q && (!row_valid_q || row_ready);
    assign grp_last   = fill_flushed_q || (grp_cnt_q == CNT_W'(ROWS_PER_SUM - 1));

    // Fill stage next state. Lanes are zeroed whenever the fill empties, so a flush
    // needs no explicit padding: untouched lanes are already zero.
    always_comb begin
        fill_d         = fill_q;
        fill_cnt_d     = fill_cnt_q;
        fill_full_d    = fill_full_q;
        fill_flushed_d = fill_flushed_q;

        if (transfer) begin
            fill_d         = '0;
            fill_cnt_d     = '0;
            fill_full_d    = 1'b0;
            fill_flushed_d = 1'b0;
        end else begin
            if (word_acc) begin
                for (int k = 0; k < int'(NI); k++) begin
                    if (fill_cnt_q == FILL_W'(k)) begin
                        fill_d[k] = word_in;
                    end
                end
                fill_cnt_d = fill_cnt_q + FILL_W'(1);
                if (fill_cnt_q == FILL_W'(NI - 1)) begin
                    fill_full_d = 1'b1;
                end
            end
            // A flush on an empty fill with no word alongside closes nothing.
            if (flush_acc && (word_acc || (fill_cnt_q != '0))) begin
                fill_full_d    = 1'b1;
                fill_flushed_d = 1'b1;
            end
        end
    end

    // Output stage and group counter next state
    always_comb begin
        row_d       = row_q;
        row_valid_d = row_valid_q;
        row_last_d  = row_last_q;
        row_index_d = row_index_q;
        grp_cnt_d   = grp_cnt_q;

        if (transfer) begin
            row_d       = fill_q;
            row_valid_d = 1'b1;
            row_last_d  = grp_last;
            row_index_d = grp_cnt_q;
            grp_cnt_d   = grp_last ? '0 : grp_cnt_q + CNT_W'(1);
        end else if (row_valid_q && row_ready) begin
            row_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q         <= '0;
            fill_cnt_q     <= '0;
            fill_full_q    <= 1'b0;
            fill_flushed_q <= 1'b0;
            row_q          <= '0;
            row_valid_q    <= 1'b0;
            row_last_q     <= 1'b0;
            row_index_q    <= '0;
            grp_cnt_q      <= '0;
        end else begin
            fill_q         <= fill_d;
            fill_cnt_q     <= fill_cnt_d;
            fill_full_q    <= fill_full_d;
            fill_flushed_q <= fill_flushed_d;
            row_q          <= row_d;
            row_valid_q    <= row_valid_d;
            row_last_q     <= row_last_d;
            row_index_q    <= row_index_d;
            grp_cnt_q      <= grp_cnt_d;
        end
    end

    assign row_out   = row_q;
    assign row_valid = row_valid_q;
    assign row_last  = row_last_q;
    assign row_index = row_index_q;

endmodule

// File: tb/tb_row_packer.sv
// Directed self-checking bench for row_packer (NI=8, ROWS_PER_SUM=4, CNT_W=8).
module tb_row_packer;

    localparam int NI    = 8;
    localparam int RPS   = 4;
    localparam int CNT_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       word_in;
    logic              word_valid;
    logic              word_ready;
    logic              flush;
    logic [NI*32-1:0]  row_out;
    logic              row_valid;
    logic              row_ready;
    logic              row_last;
    logic [CNT_W-1:0]  row_index;

    int n_vec = 0;
    int n_err = 0;

    logic [NI*32-1:0] rq_data[$];
    logic             rq_last[$];
    logic [CNT_W-1:0] rq_idx[$];
    int               n_valid_cycles = 0;

    row_packer #(.NI(NI), .ROWS_PER_SUM(RPS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .flush      (flush),
        .row_out    (row_out),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_last   (row_last),
        .row_index  (row_index)
    );

    always #5 clk = ~clk;

    // Record every row handed over downstream
    always @(posedge clk) begin
        if (!reset && row_valid) begin
            n_valid_cycles++;
            if (row_ready) begin
                rq_data.push_back(row_out);
                rq_last.push_back(row_last);
                rq_idx.push_back(row_index);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        word_valid = 1'b0;
        flush      = 1'b0;
        word_in    = '0;
        tick();
        tick();
        reset = 1'b0;
        rq_data.delete();
        rq_last.delete();
        rq_idx.delete();
        n_valid_cycles = 0;
    endtask

    // Offer one word (optionally with flush) and hold it until accepted
    task automatic send(input logic [31:0] w, input logic fl, input logic wv);
        int waited = 0;
        word_in    = w;
        flush      = fl;
        word_valid = wv;
        while (!word_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!word_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: word_ready got 0 want 1 after %0d cycles", waited);
        end
        tick();
        word_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset;
        do_reset();
        n_vec++; if (row_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_row_valid: got %b want 0", row_valid); end
        n_vec++; if (row_last !== 1'b0) begin n_err++;
            $display("FAIL reset_row_last: got %b want 0", row_last); end
        n_vec++; if (row_index !== 8'd0) begin n_err++;
            $display("FAIL reset_row_index: got %0d want 0", row_index); end
        n_vec++; if (row_out !== '0) begin n_err++;
            $display("FAIL reset_row_out: got %h want 0", row_out); end
        n_vec++; if (word_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_word_ready: got %b want 1", word_ready); end
    endtask

    task automatic test_single_row;
        do_reset();
        row_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(32'(i), 1'b0, 1'b1);
        // Cycle after the 8th word: fill full, row not yet out
        n_vec++; if (row_valid !== 1'b0) begin n_err++;
            $display("FAIL single_early_valid: got %b want 0", row_valid); end
        n_vec++; if (word_ready !== 1'b0) begin n_err++;
            $display("FAIL single_full_ready: got %b want 0", word_ready); end
        tick();
        n_vec++; if (row_valid !== 1'b1) begin n_err++;
            $display("FAIL single_valid: got %b want 1", row_valid); end
        n_vec++; if (word_ready !== 1'b1) begin n_err++;
            $display("FAIL single_ready_back: got %b want 1", word_ready); end
        for (int k = 0; k < NI; k++) begin
            n_vec++; if (row_out[32*k +: 32] !== 32'(k + 1)) begin n_err++;
                $display("FAIL single_lane%0d: got %h want %h", k, row_out[32*k +: 32], k + 1);
            end
        end
        n_vec++; if (row_index !== 8'd0) begin n_err++;
            $display("FAIL single_index: got %0d want 0", row_index); end
        n_vec++; if (row_last !== 1'b0) begin n_err++;
            $display("FAIL single_last: got %b want 0", row_last); end
        tick();
        n_vec++; if (row_valid !== 1'b0) begin n_err++;
            $display("FAIL single_valid_drop: got %b want 0", row_valid); end
        idle(3);
        n_vec++; if (n_valid_cycles !== 1) begin n_err++;
            $display("FAIL single_valid_cycles: got %0d want 1", n_valid_cycles); end
        n_vec++; if (rq_data.size() !== 1) begin n_err++;
            $display("FAIL single_row_count: got %0d want 1", rq_data.size()); end
    endtask

    task automatic test_group;
        logic [CNT_W-1:0] exp_idx[5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        logic             exp_last[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        row_ready = 1'b1;
        for (int i = 0; i < 40; i++) send(32'(100 + i), 1'b0, 1'b1);
        idle(5);
        n_vec++; if (rq_data.size() !== 5) begin n_err++;
            $display("FAIL group_row_count: got %0d want 5", rq_data.size()); end
        for (int r = 0; r < 5 && r < rq_data.size(); r++) begin
            n_vec++; if (rq_idx[r] !== exp_idx[r]) begin n_err++;
                $display("FAIL group_index%0d: got %0d want %0d", r, rq_idx[r], exp_idx[r]); end
            n_vec++; if (rq_last[r] !== exp_last[r]) begin n_err++;
                $display("FAIL group_last%0d: got %b want %b", r, rq_last[r], exp_last[r]); end
            n_vec++; if (rq_data[r][31:0] !== 32'(100 + 8 * r)) begin n_err++;
                $display("FAIL group_lane0_row%0d: got %h want %h", r, rq_data[r][31:0],
                         100 + 8 * r); end
            n_vec++; if (rq_data[r][255:224] !== 32'(107 + 8 * r)) begin n_err++;
                $display("FAIL group_lane7_row%0d: got %h want %h", r, rq_data[r][255:224],
                         107 + 8 * r); end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        row_ready = 1'b0;
        for (int i = 1; i <= 16; i++) send(32'(i), 1'b0, 1'b1);
        n_vec++; if (word_ready !== 1'b0) begin n_err++;
            $display("FAIL bp_ready_low: got %b want 0", word_ready); end
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (row_valid !== 1'b1 || row_out[31:0] !== 32'd1 ||
                         row_out[255:224] !== 32'd8 || row_index !== 8'd0) begin n_err++;
                $display("FAIL bp_hold%0d: valid %b lane0 %h lane7 %h idx %0d want 1 1 8 0", c,
                         row_valid, row_out[31:0], row_out[255:224], row_index); end
            tick();
        end
        row_ready = 1'b1;
        n_vec++; if (word_ready !== 1'b0) begin n_err++;
            $display("FAIL bp_ready_before_xfer: got %b want 0", word_ready); end
        tick();
        n_vec++; if (row_valid !== 1'b1 || row_out[31:0] !== 32'd9 || row_index !== 8'd1)
            begin n_err++;
            $display("FAIL bp_second_row: valid %b lane0 %h idx %0d want 1 9 1",
                     row_valid, row_out[31:0], row_index); end
        n_vec++; if (word_ready !== 1'b1) begin n_err++;
            $display("FAIL bp_ready_after_xfer: got %b want 1", word_ready); end
        tick();
        n_vec++; if (row_valid !== 1'b0) begin n_err++;
            $display("FAIL bp_valid_drop: got %b want 0", row_valid); end
        n_vec++; if (rq_data.size() !== 2) begin n_err++;
            $display("FAIL bp_row_count: got %0d want 2", rq_data.size()); end
        else begin
            n_vec++; if (rq_data[0][31:0] !== 32'd1 || rq_data[1][31:0] !== 32'd9) begin
                n_err++;
                $display("FAIL bp_order: got %h %h want 1 9", rq_data[0][31:0],
                         rq_data[1][31:0]); end
        end
    endtask

    task automatic test_flush;
        logic [NI*32-1:0] exp_row;
        do_reset();
        row_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(32'(200 + i), 1'b0, 1'b1);
        send(32'hAAAA_0001, 1'b0, 1'b1);
        send(32'hBBBB_0002, 1'b0, 1'b1);
        send(32'hCCCC_0003, 1'b0, 1'b1);
        send(32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send(32'(300 + i), 1'b0, 1'b1);
        idle(5);
        exp_row = '0;
        exp_row[31:0]  = 32'hAAAA_0001;
        exp_row[63:32] = 32'hBBBB_0002;
        exp_row[95:64] = 32'hCCCC_0003;
        n_vec++; if (rq_data.size() !== 3) begin n_err++;
            $display("FAIL flush_row_count: got %0d want 3", rq_data.size()); end
        else begin
            n_vec++; if (rq_data[1] !== exp_row) begin n_err++;
                $display("FAIL flush_row_data: got %h want %h", rq_data[1], exp_row); end
            n_vec++; if (rq_last[1] !== 1'b1 || rq_idx[1] !== 8'd1) begin n_err++;
                $display("FAIL flush_row_tag: last %b idx %0d want 1 1", rq_last[1], rq_idx[1]);
            end
            n_vec++; if (rq_last[2] !== 1'b0 || rq_idx[2] !== 8'd0 ||
                         rq_data[2][31:0] !== 32'd300) begin n_err++;
                $display("FAIL flush_next_row: last %b idx %0d lane0 %h want 0 0 12c",
                         rq_last[2], rq_idx[2], rq_data[2][31:0]); end
        end
    endtask

    task automatic test_flush_with_word;
        do_reset();
        row_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(32'(16 + i), 1'b0, 1'b1);
        send(32'd22, 1'b1, 1'b1);
        idle(4);
        // Flush with empty fill must not produce a row
        send(32'h0, 1'b1, 1'b0);
        idle(4);
        n_vec++; if (rq_data.size() !== 1) begin n_err++;
            $display("FAIL flushw_row_count: got %0d want 1", rq_data.size()); end
        else begin
            n_vec++; if (rq_data[0][223:0] !== 224'h00000016_00000015_00000014_00000013_00000012_00000011_00000010)
                begin n_err++;
                $display("FAIL flushw_lanes0_6: got %h", rq_data[0][223:0]); end
            n_vec++; if (rq_data[0][255:224] !== 32'd0) begin n_err++;
                $display("FAIL flushw_lane7: got %h want 0", rq_data[0][255:224]); end
            n_vec++; if (rq_last[0] !== 1'b1 || rq_idx[0] !== 8'd0) begin n_err++;
                $display("FAIL flushw_tag: last %b idx %0d want 1 0", rq_last[0], rq_idx[0]);
            end
        end
        n_vec++; if (row_valid !== 1'b0) begin n_err++;
            $display("FAIL flushw_empty_valid: got %b want 0", row_valid); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        row_ready = 1'b0;
        for (int i = 0; i < 13; i++) send(32'(40 + i), 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (row_valid !== 1'b0 || word_ready !== 1'b1 || row_index !== 8'd0) begin
            n_err++;
            $display("FAIL midreset_state: valid %b ready %b idx %0d want 0 1 0",
                     row_valid, word_ready, row_index); end
        rq_data.delete();
        rq_last.delete();
        rq_idx.delete();
        row_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(32'(80 + i), 1'b0, 1'b1);
        idle(4);
        n_vec++; if (rq_data.size() !== 1) begin n_err++;
            $display("FAIL midreset_row_count: got %0d want 1", rq_data.size()); end
        else begin
            n_vec++; if (rq_data[0][31:0] !== 32'd80 || rq_data[0][255:224] !== 32'd87 ||
                         rq_idx[0] !== 8'd0 || rq_last[0] !== 1'b0) begin n_err++;
                $display("FAIL midreset_row: lane0 %h lane7 %h idx %0d last %b want 50 57 0 0",
                         rq_data[0][31:0], rq_data[0][255:224], rq_idx[0], rq_last[0]); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        word_in    = '0;
        word_valid = 1'b0;
        flush      = 1'b0;
        row_ready  = 1'b0;
        test_reset();
        test_single_row();
        test_group();
        test_backpressure();
        test_flush();
        test_flush_with_word();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
